// File: rtl/qspi_read_arbiter.sv
// qspi_read_arbiter: two-requester round-robin arbiter in front of a single QSPI line-read engine.
//
// Ports
//   clk, rst_n                  clock and synchronous active-low reset
//   req0_valid/addr/ready       requester 0 (instruction fetch) line read request
//   rsp0_valid/data/err/ready   requester 0 line response (err = timeout)
//   req1_valid/addr/ready       requester 1 (data port) line read request
//   rsp1_valid/data/err/ready   requester 1 line response (err = timeout)
//   q_rready                    qspi_interface idle and able to accept a read
//   q_read_en, q_addr           one-cycle read strobe and 16-byte aligned line address
//   q_dval, q_dout              one-cycle data-valid pulse and line data
module qspi_read_arbiter #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic [31:0]  req0_addr,
   output logic         req0_ready,
   output logic         rsp0_valid,
   output logic [127:0] rsp0_data,
   output logic         rsp0_err,
   input  logic         rsp0_ready,
   input  logic         req1_valid,
   input  logic [31:0]  req1_addr,
   output logic         req1_ready,
   output logic         rsp1_valid,
   output logic [127:0] rsp1_data,
   output logic         rsp1_err,
   input  logic         rsp1_ready,
   input  logic         q_rready,
   output logic         q_read_en,
   output logic [31:0]  q_addr,
   input  logic         q_dval,
   input  logic [127:0] q_dout
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   state_e         state_q, state_d;
   logic           last_q, last_d;
   logic           owner_q, owner_d;
   logic [31:0]    addr_q, addr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [127:0]   data0_q, data0_d, data1_q, data1_d;
   logic           err0_q, err0_d, err1_q, err1_d;
   logic           gnt;

   // On a tie the requester that was not served last wins; otherwise whoever is asking.
   assign gnt       = (req0_valid & req1_valid) ? ~last_q : req1_valid;
   assign q_addr    = addr_q;
   assign rsp0_data = data0_q;
   assign rsp1_data = data1_q;
   assign rsp0_err  = err0_q;
   assign rsp1_err  = err1_q;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      owner_d    = owner_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      data0_d    = data0_q;
      data1_d    = data1_q;
      err0_d     = err0_q;
      err1_d     = err1_q;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp0_valid = 1'b0;
      rsp1_valid = 1'b0;
      q_read_en  = 1'b0;
      case (state_q)
         IDLE: begin
            req0_ready = req0_valid & ~gnt;
            req1_ready = req1_valid & gnt;
            if (req0_ready | req1_ready) begin
               owner_d = gnt;
               addr_d  = (gnt ? req1_addr : req0_addr) & ~32'hF;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            q_read_en = q_rready;
            if (q_rready) begin
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // Data arriving on the final counted cycle still wins over the timeout.
            if (q_dval) begin
               if (owner_q) begin
                  data1_d = q_dout;
                  err1_d  = 1'b0;
               end else begin
                  data0_d = q_dout;
                  err0_d  = 1'b0;
               end
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               if (owner_q) begin
                  data1_d = '0;
                  err1_d  = 1'b1;
               end else begin
                  data0_d = '0;
                  err0_d  = 1'b1;
               end
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            rsp0_valid = ~owner_q;
            rsp1_valid = owner_q;
            if (owner_q ? rsp1_ready : rsp0_ready) begin
               last_d  = owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Handshake outputs are forced quiet while reset is held, before the state register clears.
      if (!rst_n) begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
         rsp0_valid = 1'b0;
         rsp1_valid = 1'b0;
         q_read_en  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         data0_q <= '0;
         data1_q <= '0;
         err0_q  <= 1'b0;
         err1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         err0_q  <= err0_d;
         err1_q  <= err1_d;
      end
   end
endmodule

// File: tb/tb_qspi_read_arbiter.sv
// tb_qspi_read_arbiter: directed and randomized checks of qspi_read_arbiter against a transaction model.
module tb_qspi_read_arbiter;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready, rsp0_valid, rsp0_err, rsp0_ready;
   logic         req1_valid, req1_ready, rsp1_valid, rsp1_err, rsp1_ready;
   logic [31:0]  req0_addr, req1_addr, q_addr;
   logic [127:0] rsp0_data, rsp1_data, q_dout;
   logic         q_rready, q_read_en, q_dval;

   int checks = 0;
   int failures = 0;

   // Transaction model: one outstanding line read, tracked as accepted -> issued -> answered.
   bit           m_pend, m_fly, m_done, m_last, m_own;
   logic [31:0]  m_addr;
   int           m_wait;
   logic [127:0] m_data [2];
   bit           m_err [2];
   bit           acc [2];

   always #5 clk = ~clk;

   qspi_read_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
      .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err), .rsp0_ready(rsp0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
      .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err), .rsp1_ready(rsp1_ready),
      .q_rready(q_rready), .q_read_en(q_read_en), .q_addr(q_addr),
      .q_dval(q_dval), .q_dout(q_dout)
   );

   task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic compare();
      bit free, w;
      free = !(m_pend || m_fly || m_done);
      w = (req0_valid && req1_valid) ? !m_last : req1_valid;
      chk("req0_ready", req0_ready, rst_n && free && req0_valid && !w);
      chk("req1_ready", req1_ready, rst_n && free && req1_valid && w);
      chk("q_read_en", q_read_en, rst_n && m_pend && q_rready);
      chk("q_addr", q_addr, m_addr);
      chk("rsp0_valid", rsp0_valid, rst_n && m_done && !m_own);
      chk("rsp1_valid", rsp1_valid, rst_n && m_done && m_own);
      chk("rsp0_data", rsp0_data, m_data[0]);
      chk("rsp1_data", rsp1_data, m_data[1]);
      chk("rsp0_err", rsp0_err, m_err[0]);
      chk("rsp1_err", rsp1_err, m_err[1]);
   endtask

   task automatic model_next();
      bit w;
      logic [31:0] a;
      acc[0] = 0;
      acc[1] = 0;
      if (!rst_n) begin
         {m_pend, m_fly, m_done, m_own} = '0;
         m_last = 1;
         m_addr = '0;
         m_wait = 0;
         m_data[0] = '0;
         m_data[1] = '0;
         m_err[0] = 0;
         m_err[1] = 0;
      end else if (m_pend) begin
         if (q_rready) begin
            m_pend = 0;
            m_fly = 1;
            m_wait = 0;
         end
      end else if (m_fly) begin
         if (q_dval || m_wait == TO - 1) begin
            m_data[m_own] = q_dval ? q_dout : '0;
            m_err[m_own] = !q_dval;
            m_fly = 0;
            m_done = 1;
         end else m_wait++;
      end else if (m_done) begin
         if (m_own ? rsp1_ready : rsp0_ready) begin
            m_done = 0;
            m_last = m_own;
         end
      end else begin
         w = (req0_valid && req1_valid) ? !m_last : req1_valid;
         if (w ? req1_valid : req0_valid) begin
            acc[w] = 1;
            m_own = w;
            a = w ? req1_addr : req0_addr;
            m_addr = {a[31:4], 4'h0};
            m_pend = 1;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      compare();
      model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(output int n);
      n = 0;
      while (!(rsp0_valid || rsp1_valid) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) chk("wait_rsp_bound", 0, 1);
   endtask

   // Serve one request with data in the first wait cycle: response three edges after acceptance.
   task automatic serve(bit own);
      logic [127:0] d;
      d = {4{32'hC0DE_0000 | 32'(own)}};
      #1;
      chk(own ? "tie_ready1" : "tie_ready0", own ? req1_ready : req0_ready, 1);
      chk(own ? "tie_other0" : "tie_other1", own ? req0_ready : req1_ready, 0);
      step();
      if (own) req1_valid = 0; else req0_valid = 0;
      q_rready = 1;
      step();
      q_dval = 1;
      q_dout = d;
      step();
      q_dval = 0;
      #1;
      chk("min_lat_valid", own ? rsp1_valid : rsp0_valid, 1);
      chk("min_lat_data", own ? rsp1_data : rsp0_data, d);
      if (own) rsp1_ready = 1; else rsp0_ready = 1;
      step();
      rsp0_ready = 0;
      rsp1_ready = 0;
   endtask

   initial begin
      int n;
      logic [127:0] held;
      rst_n = 0;
      {req0_valid, req1_valid, rsp0_ready, rsp1_ready, q_rready, q_dval} = '0;
      req0_addr = '0;
      req1_addr = '0;
      q_dout = '0;
      req0_valid = 1;
      step();
      #1 chk("reset_ready0", req0_ready, 0);
      req0_valid = 0;
      step();
      rst_n = 1;
      #1;
      chk("reset_q_addr", q_addr, 0);
      chk("reset_rsp0_data", rsp0_data, 0);

      // Single request with data ten cycles into the wait.
      req0_valid = 1;
      req0_addr = 32'h0000_1234;
      q_rready = 1;
      #1 chk("single_ready", req0_ready, 1);
      step();
      req0_valid = 0;
      #1;
      chk("single_read_en", q_read_en, 1);
      chk("single_q_addr", q_addr, 32'h0000_1230);
      step();
      for (int i = 0; i < 9; i++) step();
      q_dval = 1;
      q_dout = {16{8'hA5}};
      step();
      q_dval = 0;
      #1;
      chk("single_rsp_valid", rsp0_valid, 1);
      chk("single_rsp_data", rsp0_data, {16{8'hA5}});
      chk("single_rsp_err", rsp0_err, 0);
      chk("single_rsp1_quiet", rsp1_valid, 0);
      rsp0_ready = 1;
      step();
      rsp0_ready = 0;
      #1 chk("single_data_hold", rsp0_data, {16{8'hA5}});

      // Reset again, then a tie from reset alternates 0,1,0,1.
      rst_n = 0;
      step();
      rst_n = 1;
      req0_valid = 1; req0_addr = 32'h100;
      req1_valid = 1; req1_addr = 32'h200;
      serve(0);
      serve(1);
      req0_valid = 1;
      req1_valid = 1;
      serve(0);
      serve(1);

      // Engine busy for 50 cycles after accept: no strobe, no timeout.
      req0_valid = 1;
      q_rready = 0;
      step();
      req0_valid = 0;
      for (int i = 0; i < 50; i++) step();
      #1 chk("stall_no_read_en", q_read_en, 0);
      q_rready = 1;
      #1 chk("stall_read_en", q_read_en, 1);
      step();
      q_dval = 1;
      step();
      q_dval = 0;
      rsp0_ready = 1;
      step();
      rsp0_ready = 0;

      // Timeout on requester 1, then a late q_dval is ignored and the next request works.
      req1_valid = 1;
      req1_addr = 32'hABCD_0008;
      step();
      req1_valid = 0;
      step();
      wait_rsp(n);
      chk("timeout_cycles", n, TO);
      chk("timeout_err", rsp1_err, 1);
      chk("timeout_data", rsp1_data, 0);
      rsp1_ready = 1;
      step();
      rsp1_ready = 0;
      q_dval = 1;
      q_dout = '1;
      step();
      q_dval = 0;
      #1 chk("late_dval_ignored", rsp1_valid, 0);
      req1_valid = 1;
      serve(1);

      // Response held back 20 cycles while requester 1 waits.
      req0_valid = 1;
      step();
      req0_valid = 0;
      step();
      q_dval = 1;
      q_dout = {4{32'h1357_9BDF}};
      step();
      q_dval = 0;
      held = rsp0_data;
      req1_valid = 1;
      for (int i = 0; i < 20; i++) step();
      #1;
      chk("hold_valid", rsp0_valid, 1);
      chk("hold_data", rsp0_data, {4{32'h1357_9BDF}});
      chk("hold_no_req1", req1_ready, 0);
      rsp0_ready = 1;
      step();
      rsp0_ready = 0;
      #1 chk("after_hold_req1", req1_ready, 1);
      step();
      req1_valid = 0;
      step();
      q_dval = 1;
      step();
      q_dval = 0;
      rsp1_ready = 1;
      step();
      rsp1_ready = 0;

      // Reset during the wait abandons the read.
      req0_valid = 1;
      step();
      req0_valid = 0;
      step();
      step();
      rst_n = 0;
      #1 chk("rst_wait_read_en", q_read_en, 0);
      step();
      #1;
      chk("rst_wait_q_addr", q_addr, 0);
      chk("rst_wait_rsp0", rsp0_valid, 0);
      rst_n = 1;
      q_dval = 1;
      step();
      q_dval = 0;
      for (int i = 0; i < 5; i++) step();
      #1 chk("rst_wait_no_rsp", rsp0_valid, 0);

      // Randomized traffic; requesters hold valid and address until accepted.
      for (int c = 0; c < 4000; c++) begin
         rst_n = ($urandom_range(0, 799) != 0);
         if (!req0_valid || acc[0]) begin
            req0_valid = ($urandom_range(0, 2) == 0);
            req0_addr = $urandom;
         end
         if (!req1_valid || acc[1]) begin
            req1_valid = ($urandom_range(0, 2) == 0);
            req1_addr = $urandom;
         end
         rsp0_ready = $urandom_range(0, 1);
         rsp1_ready = $urandom_range(0, 1);
         q_rready = ($urandom_range(0, 3) != 0);
         q_dval = ($urandom_range(0, 7) == 0);
         q_dout = {$urandom, $urandom, $urandom, $urandom};
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
